// File: rtl/bf_prog_mem_if.sv
// bf_prog_mem_if: bundles the program-loader handshake, load status and
// instruction-fetch port of bf_prog_mem.
//   slave  : the program memory (receives load bytes and fetch addresses)
//   master : the loader / fetch side (drives bytes and addresses)
// Signals:
//   load_start, ld_valid, ld_data -> loader stimulus
//   ld_ready, ld_done, ld_ovf, ld_unbal, busy, prog_len -> loader status
//   rd_addr -> fetch address; code, rom_overrun -> fetched result
interface bf_prog_mem_if #(
    parameter int ADDR_W = 10
);
    logic              load_start;
    logic              ld_valid;
    logic [7:0]        ld_data;
    logic              ld_ready;
    logic              ld_done;
    logic              ld_ovf;
    logic              ld_unbal;
    logic              busy;
    logic [ADDR_W:0]   prog_len;
    logic [ADDR_W-1:0] rd_addr;
    logic [2:0]        code;
    logic              rom_overrun;

    modport slave (
        input  load_start, ld_valid, ld_data, rd_addr,
        output ld_ready, ld_done, ld_ovf, ld_unbal, busy, prog_len,
               code, rom_overrun
    );

    modport master (
        output load_start, ld_valid, ld_data, rd_addr,
        input  ld_ready, ld_done, ld_ovf, ld_unbal, busy, prog_len,
               code, rom_overrun
    );
endinterface

// File: rtl/bf_prog_mem.sv
// bf_prog_mem: Brainfuck program store. A loader streams ASCII program text;
// opcode characters are compacted into a 3-bit instruction RAM, everything
// else is filtered out, and 0x00 or '!' ends the load. Bracket balance and
// capacity overflow are tracked as sticky flags. A registered fetch port
// returns the opcode one cycle after the address, reporting overrun (and
// returning INC) past the end of the program or while a load is in progress.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - bf_prog_mem_if.slave (loader handshake, status, fetch port)
module bf_prog_mem #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    bf_prog_mem_if.slave bus
);
    localparam int              MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [2:0]      OP_INC  = 3'b111;
    localparam logic [2:0]      OP_OPEN = 3'b011;
    localparam logic [2:0]      OP_CLOSE = 3'b010;

    typedef enum logic {IDLE, LOAD} state_t;
    state_t state, state_nx;

    logic [2:0]      mem [0:DEPTH-1];
    logic [ADDR_W:0] prog_len;
    logic [ADDR_W:0] depth;
    logic            ovf, unbal, done;
    logic [2:0]      rd_q;
    logic            ovr_q;

    logic            is_op, is_term, accept, has_room, wr_en;
    logic [2:0]      op;

    // Byte classification
    always_comb begin
        is_op   = 1'b1;
        is_term = 1'b0;
        op      = 3'b000;
        case (bus.ld_data)
            8'h2B: op = 3'b111;        // '+'
            8'h2D: op = 3'b110;        // '-'
            8'h3E: op = 3'b101;        // '>'
            8'h3C: op = 3'b100;        // '<'
            8'h5B: op = 3'b011;        // '['
            8'h5D: op = 3'b010;        // ']'
            8'h2E: op = 3'b001;        // '.'
            8'h2C: op = 3'b000;        // ','
            8'h00, 8'h21: begin        // NUL or '!' ends the load
                is_op   = 1'b0;
                is_term = 1'b1;
            end
            default: is_op = 1'b0;     // whitespace/comments
        endcase
    end

    // A load_start in the same cycle wins: the byte is dropped and the load restarts.
    assign accept   = (state == LOAD) && bus.ld_valid && !bus.load_start;
    assign has_room = prog_len < DEPTH_L;
    assign wr_en    = accept && is_op && has_room;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        if (bus.load_start)          state_nx = LOAD;
        else if (accept && is_term)  state_nx = IDLE;
    end

    // FSM: outputs
    always_comb begin
        bus.ld_ready = (state == LOAD);
        bus.busy     = (state == LOAD);
    end

    // Load bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_len <= '0;
            depth    <= '0;
            ovf      <= 1'b0;
            unbal    <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus.load_start) begin
                prog_len <= '0;
                depth    <= '0;
                ovf      <= 1'b0;
                unbal    <= 1'b0;
            end else if (accept) begin
                if (is_term) begin
                    done <= 1'b1;
                    if (depth != '0) unbal <= 1'b1;
                end else if (is_op) begin
                    if (!has_room) begin
                        ovf <= 1'b1;   // discarded, brackets not counted
                    end else begin
                        prog_len <= prog_len + 1'b1;
                        if (op == OP_OPEN) begin
                            depth <= depth + 1'b1;
                        end else if (op == OP_CLOSE) begin
                            if (depth == '0) unbal <= 1'b1;
                            else             depth <= depth - 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Instruction RAM: one write, one registered read, read-before-write.
    // Reads beyond DEPTH land on don't-care data that the overrun flag masks.
    always_ff @(posedge clk) begin
        if (wr_en) mem[prog_len[MEM_AW-1:0]] <= op;
        rd_q <= mem[bus.rd_addr[MEM_AW-1:0]];
    end

    // Overrun flag is reset so the fetch port reads INC/overrun out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovr_q <= 1'b1;
        else        ovr_q <= (state == LOAD) || ({1'b0, bus.rd_addr} >= prog_len);
    end

    assign bus.code        = ovr_q ? OP_INC : rd_q;
    assign bus.rom_overrun = ovr_q;
    assign bus.prog_len    = prog_len;
    assign bus.ld_done     = done;
    assign bus.ld_ovf      = ovf;
    assign bus.ld_unbal    = unbal;
endmodule

// File: tb/tb_bf_prog_mem.sv
module tb_bf_prog_mem;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start = 1'b0;
    logic          ld_valid = 1'b0;
    logic [7:0]    ld_data = 8'h00;
    logic [AW-1:0] rd_addr = '0;

    int tests = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Main instance (DEPTH 16) and small instance (DEPTH 4) share stimulus.
    bf_prog_mem_if #(.ADDR_W(AW)) bus  ();
    bf_prog_mem_if #(.ADDR_W(AW)) bus4 ();

    assign bus.load_start  = load_start;
    assign bus.ld_valid    = ld_valid;
    assign bus.ld_data     = ld_data;
    assign bus.rd_addr     = rd_addr;
    assign bus4.load_start = load_start;
    assign bus4.ld_valid   = ld_valid;
    assign bus4.ld_data    = ld_data;
    assign bus4.rd_addr    = rd_addr;

    bf_prog_mem #(.ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    bf_prog_mem #(.ADDR_W(AW), .DEPTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    // All stimulus changes land 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        ld_valid = 1'b1;
        ld_data  = b;
        tick();
        ld_valid = 1'b0;
        ld_data  = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rd_addr = '0;
        #12;
        tests++; if (bus.code !== 3'b111) begin errors++; $display("FAIL rst_code: got %b exp 111", bus.code); end
        tests++; if (bus.rom_overrun !== 1'b1) begin errors++; $display("FAIL rst_ovr: got %b exp 1", bus.rom_overrun); end
        tests++; if (bus.prog_len !== 5'd0) begin errors++; $display("FAIL rst_len: got %0d exp 0", bus.prog_len); end
        tests++; if ({bus.ld_ready, bus.busy, bus.ld_done, bus.ld_ovf, bus.ld_unbal} !== 5'b0) begin
            errors++; $display("FAIL rst_flags: got %b exp 00000", {bus.ld_ready, bus.busy, bus.ld_done, bus.ld_ovf, bus.ld_unbal});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests++; if (bus.code !== 3'b111 || bus.rom_overrun !== 1'b1) begin
            errors++; $display("FAIL rd0_after_rst: got code=%b ovr=%b exp 111/1", bus.code, bus.rom_overrun);
        end
    endtask

    task automatic test_basic();
        logic [2:0] e [0:4];
        e = '{3'b111, 3'b011, 3'b110, 3'b010, 3'b001};
        start_load();
        tests++; if (bus.busy !== 1'b1 || bus.ld_ready !== 1'b1) begin
            errors++; $display("FAIL load_busy: got busy=%b rdy=%b exp 1/1", bus.busy, bus.ld_ready);
        end
        send_str("+[-].");
        send_byte(8'h00);
        tests++; if (bus.ld_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b exp 1", bus.ld_done); end
        tests++; if (bus.prog_len !== 5'd5) begin errors++; $display("FAIL basic_len: got %0d exp 5", bus.prog_len); end
        tests++; if (bus.ld_unbal !== 1'b0 || bus.ld_ovf !== 1'b0) begin
            errors++; $display("FAIL basic_flags: got unbal=%b ovf=%b exp 0/0", bus.ld_unbal, bus.ld_ovf);
        end
        tests++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got busy=%b exp 0", bus.busy); end
        for (int i = 0; i < 5; i++) begin
            rd_addr = AW'(i);
            tick();
            if (i == 0) begin
                tests++; if (bus.ld_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b exp 0", bus.ld_done); end
            end
            tests++; if (bus.code !== e[i] || bus.rom_overrun !== 1'b0) begin
                errors++; $display("FAIL basic_rd%0d: got code=%b ovr=%b exp %b/0", i, bus.code, bus.rom_overrun, e[i]);
            end
        end
        rd_addr = AW'(5);
        tick();
        tests++; if (bus.code !== 3'b111 || bus.rom_overrun !== 1'b1) begin
            errors++; $display("FAIL basic_rd5: got code=%b ovr=%b exp 111/1", bus.code, bus.rom_overrun);
        end
    endtask

    task automatic test_filter();
        start_load();
        send_str("+ x\n>");
        send_byte(8'h21);
        tests++; if (bus.prog_len !== 5'd2 || bus.ld_done !== 1'b1) begin
            errors++; $display("FAIL filt_len: got len=%0d done=%b exp 2/1", bus.prog_len, bus.ld_done);
        end
        rd_addr = AW'(0);
        tick();
        tests++; if (bus.code !== 3'b111 || bus.rom_overrun !== 1'b0) begin
            errors++; $display("FAIL filt_rd0: got code=%b ovr=%b exp 111/0", bus.code, bus.rom_overrun);
        end
        rd_addr = AW'(1);
        tick();
        tests++; if (bus.code !== 3'b101 || bus.rom_overrun !== 1'b0) begin
            errors++; $display("FAIL filt_rd1: got code=%b ovr=%b exp 101/0", bus.code, bus.rom_overrun);
        end
        rd_addr = AW'(2);
        tick();
        tests++; if (bus.rom_overrun !== 1'b1) begin errors++; $display("FAIL filt_rd2: got ovr=%b exp 1", bus.rom_overrun); end
    endtask

    task automatic test_overflow();
        start_load();
        send_str("+++++[");
        send_byte(8'h00);
        tests++; if (bus4.prog_len !== 5'd4 || bus4.ld_ovf !== 1'b1 || bus4.ld_unbal !== 1'b0) begin
            errors++; $display("FAIL ovf_d4: got len=%0d ovf=%b unbal=%b exp 4/1/0", bus4.prog_len, bus4.ld_ovf, bus4.ld_unbal);
        end
        // Same text on the deep instance: fits, but the '[' is left open.
        tests++; if (bus.prog_len !== 5'd6 || bus.ld_ovf !== 1'b0 || bus.ld_unbal !== 1'b1) begin
            errors++; $display("FAIL ovf_d16: got len=%0d ovf=%b unbal=%b exp 6/0/1", bus.prog_len, bus.ld_ovf, bus.ld_unbal);
        end
        rd_addr = AW'(3);
        tick();
        tests++; if (bus4.code !== 3'b111 || bus4.rom_overrun !== 1'b0) begin
            errors++; $display("FAIL ovf_rd3: got code=%b ovr=%b exp 111/0", bus4.code, bus4.rom_overrun);
        end
        rd_addr = AW'(4);
        tick();
        tests++; if (bus4.rom_overrun !== 1'b1) begin errors++; $display("FAIL ovf_rd4: got ovr=%b exp 1", bus4.rom_overrun); end
    endtask

    task automatic test_unbal();
        start_load();
        send_str("]");
        send_byte(8'h00);
        tests++; if (bus.ld_unbal !== 1'b1 || bus.prog_len !== 5'd1) begin
            errors++; $display("FAIL unbal_close: got unbal=%b len=%0d exp 1/1", bus.ld_unbal, bus.prog_len);
        end
        start_load();
        tests++; if (bus.ld_unbal !== 1'b0) begin errors++; $display("FAIL unbal_clear: got %b exp 0", bus.ld_unbal); end
        send_str("[[");
        tests++; if (bus.ld_unbal !== 1'b0) begin errors++; $display("FAIL unbal_open_early: got %b exp 0", bus.ld_unbal); end
        send_byte(8'h00);
        tests++; if (bus.ld_unbal !== 1'b1 || bus.ld_done !== 1'b1) begin
            errors++; $display("FAIL unbal_open_done: got unbal=%b done=%b exp 1/1", bus.ld_unbal, bus.ld_done);
        end
    endtask

    task automatic test_restart_reset();
        tick();
        start_load();
        send_str("++");
        tests++; if (bus.prog_len !== 5'd2) begin errors++; $display("FAIL rs_len2: got %0d exp 2", bus.prog_len); end
        // Restart with a byte presented in the same cycle; the byte is dropped.
        rd_addr    = AW'(0);
        load_start = 1'b1;
        ld_valid   = 1'b1;
        ld_data    = 8'h2B;
        tick();
        load_start = 1'b0;
        ld_valid   = 1'b0;
        tests++; if (bus.prog_len !== 5'd0 || bus.busy !== 1'b1 || bus.ld_done !== 1'b0) begin
            errors++; $display("FAIL rs_restart: got len=%0d busy=%b done=%b exp 0/1/0", bus.prog_len, bus.busy, bus.ld_done);
        end
        tests++; if (bus.rom_overrun !== 1'b1) begin errors++; $display("FAIL rs_busy_ovr: got %b exp 1", bus.rom_overrun); end
        send_str("-");
        tests++; if (bus.prog_len !== 5'd1) begin errors++; $display("FAIL rs_len1: got %0d exp 1", bus.prog_len); end
        // Asynchronous reset in the middle of the load.
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.prog_len !== 5'd0 || bus.busy !== 1'b0 || bus.ld_ready !== 1'b0) begin
            errors++; $display("FAIL rs_async: got len=%0d busy=%b rdy=%b exp 0/0/0", bus.prog_len, bus.busy, bus.ld_ready);
        end
        tests++; if (bus.code !== 3'b111 || bus.rom_overrun !== 1'b1 || bus.ld_done !== 1'b0) begin
            errors++; $display("FAIL rs_async_rd: got code=%b ovr=%b done=%b exp 111/1/0", bus.code, bus.rom_overrun, bus.ld_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests++; if (bus.busy !== 1'b0 || bus.ld_done !== 1'b0 || bus.ld_unbal !== 1'b0) begin
            errors++; $display("FAIL rs_post: got busy=%b done=%b unbal=%b exp 0/0/0", bus.busy, bus.ld_done, bus.ld_unbal);
        end
        // A byte offered in IDLE without load_start is not taken.
        send_byte(8'h2B);
        tests++; if (bus.prog_len !== 5'd0 || bus.ld_ready !== 1'b0) begin
            errors++; $display("FAIL rs_idle_byte: got len=%0d rdy=%b exp 0/0", bus.prog_len, bus.ld_ready);
        end
        start_load();
        send_str(".");
        send_byte(8'h21);
        rd_addr = AW'(0);
        tick();
        tests++; if (bus.prog_len !== 5'd1 || bus.code !== 3'b001 || bus.rom_overrun !== 1'b0) begin
            errors++; $display("FAIL rs_reload: got len=%0d code=%b ovr=%b exp 1/001/0", bus.prog_len, bus.code, bus.rom_overrun);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_filter();
        test_overflow();
        test_unbal();
        test_restart_reset();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
